// File: rtl/fir_tap_sequencer.sv
// Feeds the 16-tap MAC: keeps the sample delay line and coefficient file and
// streams TAPS back-to-back (x[n-k], h[k]) pairs for every accepted sample.
module fir_tap_sequencer #(
  parameter int TAPS = 16,
  parameter int DW   = 16,
  parameter int AW   = 4
) (
  input  logic          CLK,
  input  logic          ARST,
  input  logic          sample_valid,
  input  logic [DW-1:0] sample_in,
  output logic          sample_ready,
  input  logic          clear,
  input  logic          coef_wr_en,
  input  logic [AW-1:0] coef_wr_addr,
  input  logic [DW-1:0] coef_wr_data,
  output logic          coef_wr_err,
  output logic [DW-1:0] InData,
  output logic [DW-1:0] filterCoef,
  output logic          input_Valid,
  output logic          initialize,
  output logic          busy
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  logic [DW-1:0] dline  [TAPS];
  logic [DW-1:0] coef_q [TAPS];
  logic [AW-1:0] wp;
  logic [AW-1:0] base;
  logic [AW-1:0] k;
  logic [AW-1:0] k_nxt;
  logic          accept;
  logic          coef_ok;

  // Handshake: a sample transfers at a rising edge where sample_valid and
  // sample_ready are both high; sample_ready never depends on sample_valid.
  assign sample_ready = ~ARST & (state == IDLE) & ~clear;
  assign accept       = sample_valid & sample_ready;
  assign busy         = (state == RUN);
  assign coef_ok      = (state == IDLE) & ~accept;
  assign k_nxt        = k + 1'b1;

  always_ff @(posedge CLK or posedge ARST) begin
    if (ARST) begin
      state       <= IDLE;
      wp          <= '0;
      base        <= '0;
      k           <= '0;
      InData      <= '0;
      filterCoef  <= '0;
      input_Valid <= 1'b0;
      initialize  <= 1'b0;
      coef_wr_err <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        dline[i]  <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      coef_wr_err <= coef_wr_en & ~coef_ok;
      if (coef_wr_en & coef_ok) coef_q[coef_wr_addr] <= coef_wr_data;

      if (clear) begin
        for (int i = 0; i < TAPS; i++) dline[i] <= '0;
        wp          <= '0;
        k           <= '0;
        state       <= IDLE;
        input_Valid <= 1'b0;
        initialize  <= 1'b0;
      end else if (accept) begin
        // Tap 0 bypasses the delay line so the burst starts the next cycle.
        dline[wp]   <= sample_in;
        base        <= wp;
        wp          <= wp + 1'b1;
        k           <= '0;
        state       <= RUN;
        InData      <= sample_in;
        filterCoef  <= coef_q[0];
        input_Valid <= 1'b1;
        initialize  <= 1'b1;
      end else if (state == RUN) begin
        initialize <= 1'b0;
        if (k == AW'(TAPS - 1)) begin
          state       <= IDLE;
          input_Valid <= 1'b0;
        end else begin
          k           <= k_nxt;
          InData      <= dline[base - k_nxt];
          filterCoef  <= coef_q[k_nxt];
          input_Valid <= 1'b1;
        end
      end else begin
        input_Valid <= 1'b0;
        initialize  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Bench for fir_tap_sequencer: queue-based history model plus directed
// sequences for the test-plan corner cases and a randomized soak.
module tb_fir_tap_sequencer;
  localparam int TAPS = 16;
  localparam int DW   = 16;
  localparam int AW   = 4;

  logic          CLK = 1'b0;
  logic          ARST = 1'b0;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic          sample_ready;
  logic          clear = 1'b0;
  logic          coef_wr_en = 1'b0;
  logic [AW-1:0] coef_wr_addr = '0;
  logic [DW-1:0] coef_wr_data = '0;
  logic          coef_wr_err;
  logic [DW-1:0] InData;
  logic [DW-1:0] filterCoef;
  logic          input_Valid;
  logic          initialize;
  logic          busy;

  fir_tap_sequencer #(.TAPS(TAPS), .DW(DW), .AW(AW)) dut (
    .CLK(CLK), .ARST(ARST),
    .sample_valid(sample_valid), .sample_in(sample_in), .sample_ready(sample_ready),
    .clear(clear),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .coef_wr_err(coef_wr_err),
    .InData(InData), .filterCoef(filterCoef),
    .input_Valid(input_Valid), .initialize(initialize), .busy(busy)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: sample history (newest first), coefficients, and the
  // queue of {initialize, data, coef} pairs still to appear on the outputs
  logic [2*DW:0] exp_q[$];
  logic [DW-1:0] hist[$];
  logic [DW-1:0] m_coef[TAPS];
  logic          m_valid = 1'b0;
  logic          m_init  = 1'b0;
  logic [DW-1:0] m_data  = '0;
  logic [DW-1:0] m_cf    = '0;
  logic          m_err   = 1'b0;

  always @(posedge CLK or posedge ARST) begin
    logic idle, acc;
    logic [2*DW:0] p;
    if (ARST) begin
      exp_q.delete();
      hist.delete();
      for (int i = 0; i < TAPS; i++) m_coef[i] = '0;
      m_valid = 1'b0; m_init = 1'b0; m_data = '0; m_cf = '0; m_err = 1'b0;
    end else begin
      idle  = (exp_q.size() == 0) && !m_valid;
      acc   = sample_valid && idle && !clear;
      m_err = coef_wr_en && !(idle && !acc);
      if (clear) begin
        exp_q.delete();
        hist.delete();
        m_valid = 1'b0;
        m_init  = 1'b0;
      end else begin
        if (acc) begin
          hist.push_front(sample_in);
          if (hist.size() > TAPS) void'(hist.pop_back());
          for (int j = 0; j < TAPS; j++)
            exp_q.push_back({(j == 0), (j < hist.size()) ? hist[j] : DW'(0), m_coef[j]});
        end
        if (exp_q.size() > 0) begin
          p = exp_q.pop_front();
          m_valid = 1'b1;
          m_init  = p[2*DW];
          m_data  = p[2*DW-1:DW];
          m_cf    = p[DW-1:0];
        end else begin
          m_valid = 1'b0;
          m_init  = 1'b0;
        end
      end
      if (coef_wr_en && idle && !acc) m_coef[coef_wr_addr] = coef_wr_data;
    end
  end

  // scoreboard: every output checked against the model mid-cycle
  always @(negedge CLK) begin
    chk("sb_valid", input_Valid, m_valid);
    chk("sb_init", initialize, m_init);
    chk("sb_data", InData, m_data);
    chk("sb_coef", filterCoef, m_cf);
    chk("sb_busy", busy, m_valid);
    chk("sb_ready", sample_ready, !ARST && !m_valid && !clear);
    chk("sb_wr_err", coef_wr_err, m_err);
  end

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic accept(input logic [DW-1:0] x);
    sample_valid = 1'b1;
    sample_in    = x;
    tick();
    sample_valid = 1'b0;
  endtask

  typedef struct {
    logic [DW-1:0] exp_data;
    logic [DW-1:0] exp_coef;
    logic          exp_init;
  } vec_t;
  vec_t tbl[TAPS];

  initial begin
    logic [DW-1:0] e;
    int last_init, cyc;

    for (int k = 0; k < TAPS; k++) begin
      tbl[k].exp_data = (k == 0) ? DW'(100) : DW'(0);
      tbl[k].exp_coef = DW'(k + 1);
      tbl[k].exp_init = (k == 0);
    end

    #1 ARST = 1'b1;
    repeat (3) @(posedge CLK);
    #1 ARST = 1'b0;
    tick();

    // coef[k] = k+1
    for (int k = 0; k < TAPS; k++) begin
      coef_wr_en = 1'b1; coef_wr_addr = AW'(k); coef_wr_data = DW'(k + 1);
      tick();
    end
    coef_wr_en = 1'b0;
    tick();

    // single burst from reset against the vector table
    accept(DW'(100));
    for (int k = 0; k < TAPS; k++) begin
      @(negedge CLK);
      chk("t1_valid", input_Valid, 1'b1);
      chk("t1_init", initialize, tbl[k].exp_init);
      chk("t1_data", InData, tbl[k].exp_data);
      chk("t1_coef", filterCoef, tbl[k].exp_coef);
    end
    @(negedge CLK);
    chk("t1_end_valid", input_Valid, 1'b0);
    @(posedge CLK); #1;

    // impulse response
    clear = 1'b1; tick(); clear = 1'b0;
    for (int m = 0; m < TAPS; m++) begin
      accept((m == 0) ? DW'(1) : DW'(0));
      for (int k = 0; k < TAPS; k++) begin
        @(negedge CLK);
        if (k == m) begin
          chk("imp_one", InData, DW'(1));
          chk("imp_coef", filterCoef, DW'(m + 1));
        end else begin
          chk("imp_zero", InData, DW'(0));
        end
      end
      @(posedge CLK); #1;
    end

    // sample_valid held high: accepts every TAPS+1 cycles
    last_init = -1;
    sample_valid = 1'b1;
    for (cyc = 0; cyc < (TAPS + 1) * 5 + 3; cyc++) begin
      sample_in = DW'($urandom);
      @(negedge CLK);
      if (initialize) begin
        if (last_init >= 0) chk("spacing", cyc - last_init, TAPS + 1);
        last_init = cyc;
      end
      if (busy) chk("ready_in_run", sample_ready, 1'b0);
      @(posedge CLK); #1;
    end
    sample_valid = 1'b0;
    repeat (TAPS + 1) tick();

    // write during a burst is dropped
    accept(DW'($urandom));
    repeat (2) tick();
    coef_wr_en = 1'b1; coef_wr_addr = AW'(3); coef_wr_data = 16'h7FFF;
    tick();
    coef_wr_en = 1'b0;
    @(negedge CLK); chk("wr_err_pulse", coef_wr_err, 1'b1);
    @(negedge CLK); chk("wr_err_clear", coef_wr_err, 1'b0);
    repeat (TAPS - 2) @(posedge CLK);
    #1;

    // write coincident with an accept is dropped too
    sample_valid = 1'b1; sample_in = DW'($urandom);
    coef_wr_en = 1'b1; coef_wr_addr = AW'(5); coef_wr_data = 16'h1234;
    tick();
    sample_valid = 1'b0; coef_wr_en = 1'b0;
    @(negedge CLK); chk("acc_wr_err", coef_wr_err, 1'b1);
    for (int k = 1; k < TAPS; k++) begin
      @(negedge CLK);
      if (k == 3) chk("old_coef3", filterCoef, DW'(4));
      if (k == 5) chk("old_coef5", filterCoef, DW'(6));
    end
    @(posedge CLK); #1;

    // same address written twice: last wins
    coef_wr_en = 1'b1; coef_wr_addr = AW'(2); coef_wr_data = 16'h0AAA; tick();
    coef_wr_data = 16'h0BBB; tick();
    coef_wr_en = 1'b0;
    accept(DW'($urandom));
    for (int k = 0; k < TAPS; k++) begin
      @(negedge CLK);
      if (k == 2) chk("last_write_wins", filterCoef, 16'h0BBB);
    end
    @(posedge CLK); #1;

    // clear at tap 5; a sample offered with clear is ignored
    accept(DW'($urandom));
    repeat (5) tick();
    clear = 1'b1; sample_valid = 1'b1; sample_in = DW'(77);
    tick();
    clear = 1'b0; sample_in = DW'(-5);
    @(negedge CLK);
    chk("clr_valid", input_Valid, 1'b0);
    chk("clr_init", initialize, 1'b0);
    @(posedge CLK); #1;
    sample_valid = 1'b0;
    for (int k = 0; k < TAPS; k++) begin
      @(negedge CLK);
      e = (k == 0) ? DW'(-5) : DW'(0);
      chk("clr_data", InData, e);
      if (k == 0) begin
        chk("clr_h0", filterCoef, DW'(1));
        chk("clr_new_init", initialize, 1'b1);
      end
    end
    @(posedge CLK); #1;

    // asynchronous reset at tap 8
    accept(16'h1111);
    repeat (8) tick();
    #2 ARST = 1'b1;
    #1;
    chk("arst_valid", input_Valid, 1'b0);
    chk("arst_init", initialize, 1'b0);
    chk("arst_data", InData, DW'(0));
    chk("arst_coef", filterCoef, DW'(0));
    chk("arst_busy", busy, 1'b0);
    chk("arst_ready", sample_ready, 1'b0);
    repeat (2) @(posedge CLK);
    #1 ARST = 1'b0;
    #1 chk("post_arst_ready", sample_ready, 1'b1);
    @(posedge CLK); #1;
    accept(DW'(9));
    for (int k = 0; k < TAPS; k++) begin
      @(negedge CLK);
      e = (k == 0) ? DW'(9) : DW'(0);
      chk("post_arst_data", InData, e);
    end
    @(posedge CLK); #1;

    // randomized soak against the model
    for (int c = 0; c < 1500; c++) begin
      sample_valid = ($urandom_range(0, 3) == 0);
      sample_in    = DW'($urandom);
      clear        = ($urandom_range(0, 60) == 0);
      coef_wr_en   = ($urandom_range(0, 5) == 0);
      coef_wr_addr = AW'($urandom_range(0, TAPS - 1));
      coef_wr_data = DW'($urandom);
      tick();
    end
    sample_valid = 1'b0; clear = 1'b0; coef_wr_en = 1'b0;
    repeat (TAPS + 2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
